tx_symbol_scheduler: RTL and testbench
======================================

Name: tx_symbol_scheduler

Overview:
- Per-lane TX symbol scheduler that feeds the lane serializer's symbol input with one symbol per transfer.
- Arbitrates three sources at symbol boundaries: link-layer data packets, LTSSM ordered sets (TS1/TS2/EIOS), and periodic SKP ordered sets that it generates itself.
- Emits IDLE fill when no source is ready, so the serializer never starves.
- Sits between the lane controller and the serializer, in the core clock domain.

Parameters:
- DATA_WIDTH, 10, symbol width. Symbols are opaque codes: bit 8 is the K flag, bits 7:0 are the byte.
- SKP_INTERVAL, 1180, number of counted symbols between SKP ordered-set requests. Legal range is 4 or greater.
- SKP_COUNT, 3, number of SKP symbols following COM. Legal range is 1 to 5.
- COM_CODE, 10'h1BC, COM symbol code.
- SKP_CODE, 10'h11C, SKP symbol code.
- IDLE_CODE, 10'h000, fill symbol code.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- en_i  in  1  lane transmit enable.
- dat_valid_i  in  1  data symbol valid.
- dat_ready_o  out  1  data symbol accepted this cycle (when valid).
- dat_data_i  in  DATA_WIDTH  data symbol.
- dat_last_i  in  1  last symbol of the packet.
- os_valid_i  in  1  ordered-set symbol valid.
- os_ready_o  out  1  ordered-set symbol accepted this cycle (when valid).
- os_data_i  in  DATA_WIDTH  ordered-set symbol.
- os_last_i  in  1  last symbol of the ordered set.
- out_ready_i  in  1  serializer can take a symbol (its FIFO is not full).
- sym_data_o  out  DATA_WIDTH  symbol to serializer. Registered.
- sym_valid_o  out  1  symbol valid. Registered.
- skp_sent_o  out  1  one-cycle pulse when the final SKP of a set is loaded.
- skp_overrun_o  out  1  sticky flag: SKP deferred for 2*SKP_INTERVAL symbols.

Behaviour:
- Reset values: sym_data_o=0, sym_valid_o=0, skp_sent_o=0, skp_overrun_o=0, state=IDLE, symbol counter=0, SKP index=0.
- Load rule: advance = !sym_valid_o || out_ready_i. The output register loads only on advance; otherwise it holds data and valid.
- Latency: an input accepted in cycle N appears on sym_data_o in cycle N+1.
- Ready rules: dat_ready_o and os_ready_o are combinational and are asserted only on an advance cycle that selects that source. An input is consumed when valid && ready.
- FSM states:
  - IDLE: symbol boundary.
  - DATA: inside a packet.
  - OS: inside an ordered set.
  - SKP: emitting a SKP ordered set.
- IDLE with advance and en_i=1 selects by fixed priority:
  1. SKP pending: load COM_CODE, clear the counter, go to SKP.
  2. os_valid_i: load os_data_i. Go to OS unless os_last_i, in which case stay in IDLE.
  3. dat_valid_i: load dat_data_i. Go to DATA unless dat_last_i, in which case stay in IDLE.
  4. Otherwise: load IDLE_CODE and stay in IDLE.
- IDLE with advance and en_i=0: load sym_valid_o=0. No source is accepted.
- DATA: dat_ready_o=advance. On accept, load the symbol; dat_last_i returns to IDLE.
  - If dat_valid_i=0 mid-packet, load IDLE_CODE (underrun fill) and stay in DATA.
  - No preemption by SKP or ordered sets.
- OS: same rules as DATA, using the os_* ports.
- SKP: on each advance, load SKP_CODE and increment the SKP index. When the SKP_COUNT-th SKP is loaded, pulse skp_sent_o, clear the index, and go to IDLE.
- en_i deassert mid-DATA, mid-OS or mid-SKP: the current packet or set completes first. en_i is sampled only in IDLE.
- Symbol counter:
  - Width is $clog2(2*SKP_INTERVAL+1).
  - Increments on every load of a data, ordered-set or IDLE symbol. COM and SKP loads do not count.
  - Saturates at 2*SKP_INTERVAL.
  - SKP pending = counter >= SKP_INTERVAL.
- skp_overrun_o: set when the counter reaches 2*SKP_INTERVAL. Cleared only by reset.
- Simultaneous events:
  - SKP becomes pending while a packet is in flight: SKP is issued at the next IDLE boundary, ahead of a waiting os or dat request.
  - os and dat both valid in IDLE: os wins, and dat is stalled.
- Backpressure: when out_ready_i=0 with valid held, no input is accepted, the counter and FSM are frozen, and sym_data_o is stable.
- Reset mid-operation: state returns to IDLE immediately and asynchronously. The partial packet or set is dropped; the source must restart it.

Test Plan:
- SKP_INTERVAL=8, SKP_COUNT=3, en_i=1, no requests, out_ready_i=1 -> 8 IDLE_CODE symbols, then 1BC 11C 11C 11C, skp_sent_o pulses once, then the pattern repeats.
- 5-symbol packet (dat_last_i on symbol 5) presented at counter=6 -> all 5 symbols contiguous; COM follows immediately after symbol 5; skp_overrun_o=0.
- os_valid_i and dat_valid_i both asserted in IDLE -> 16-symbol TS1 sent first, dat_ready_o=0 throughout, then the packet is sent.
- out_ready_i held low for 4 cycles mid-packet -> sym_data_o stable, dat_ready_o=0, the counter unchanged, no symbol lost or duplicated.
- SKP_INTERVAL=8 with a 20-symbol packet started at counter=0 -> skp_overrun_o asserts on symbol 16; SKP is issued after symbol 20.
- rst_ni pulsed low mid-SKP (after COM plus 1 SKP) -> sym_valid_o=0 asynchronously; after release, IDLE resumes with the counter at 0.

Source files
------------

// File: rtl/tx_symbol_scheduler.sv
// Per-lane TX symbol scheduler: arbitrates SKP sets, ordered sets, data packets and IDLE fill into one symbol stream.
// Latency: one cycle. A symbol accepted in cycle N is on sym_data_o in cycle N+1.
// Backpressure: out_ready_i=0 with sym_valid_o held freezes the output, FSM and counter; no input is accepted.
module tx_symbol_scheduler #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    SKP_INTERVAL = 1180,
  parameter int                    SKP_COUNT    = 3,
  parameter logic [DATA_WIDTH-1:0] COM_CODE     = 10'h1BC,
  parameter logic [DATA_WIDTH-1:0] SKP_CODE     = 10'h11C,
  parameter logic [DATA_WIDTH-1:0] IDLE_CODE    = 10'h000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  dat_valid_i,
  output logic                  dat_ready_o,
  input  logic [DATA_WIDTH-1:0] dat_data_i,
  input  logic                  dat_last_i,
  input  logic                  os_valid_i,
  output logic                  os_ready_o,
  input  logic [DATA_WIDTH-1:0] os_data_i,
  input  logic                  os_last_i,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] sym_data_o,
  output logic                  sym_valid_o,
  output logic                  skp_sent_o,
  output logic                  skp_overrun_o
);

  // Counter spans 0..2*SKP_INTERVAL so the overrun point is representable.
  localparam int CW = $clog2(2 * SKP_INTERVAL + 1);
  localparam int IW = (SKP_COUNT > 1) ? $clog2(SKP_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * SKP_INTERVAL);
  localparam logic [CW-1:0] CNT_THR  = CW'(SKP_INTERVAL);
  localparam logic [IW-1:0] SKP_LAST = IW'(SKP_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_OS   = 2'd2,
    ST_SKP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sym_data_q, sym_data_d;
  logic                  sym_valid_q, sym_valid_d;
  logic                  skp_sent_q, skp_sent_d;
  logic                  overrun_q, overrun_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic advance;
  logic skp_pending;
  logic cnt_inc;
  logic cnt_clr;
  logic dat_ready;
  logic os_ready;

  assign advance     = !sym_valid_q || out_ready_i;
  assign skp_pending = (cnt_q >= CNT_THR);

  // Arbitration and FSM next state; every load happens only on an advance cycle.
  always_comb begin
    state_d     = state_q;
    sym_data_d  = sym_data_q;
    sym_valid_d = sym_valid_q;
    idx_d       = idx_q;
    skp_sent_d  = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    dat_ready   = 1'b0;
    os_ready    = 1'b0;
    if (advance) begin
      case (state_q)
        ST_IDLE: begin
          if (!en_i) begin
            sym_valid_d = 1'b0;
          end else if (skp_pending) begin
            // SKP wins the boundary even over a waiting ordered set.
            sym_data_d  = COM_CODE;
            sym_valid_d = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = ST_SKP;
          end else if (os_valid_i) begin
            os_ready    = 1'b1;
            sym_data_d  = os_data_i;
            sym_valid_d = 1'b1;
            cnt_inc     = 1'b1;
            state_d     = os_last_i ? ST_IDLE : ST_OS;
          end else if (dat_valid_i) begin
            dat_ready   = 1'b1;
            sym_data_d  = dat_data_i;
            sym_valid_d = 1'b1;
            cnt_inc     = 1'b1;
            state_d     = dat_last_i ? ST_IDLE : ST_DATA;
          end else begin
            sym_data_d  = IDLE_CODE;
            sym_valid_d = 1'b1;
            cnt_inc     = 1'b1;
          end
        end
        ST_DATA: begin
          // Packet runs to completion; a gap in the source is filled with IDLE.
          dat_ready   = 1'b1;
          sym_valid_d = 1'b1;
          cnt_inc     = 1'b1;
          if (dat_valid_i) begin
            sym_data_d = dat_data_i;
            if (dat_last_i) state_d = ST_IDLE;
          end else begin
            sym_data_d = IDLE_CODE;
          end
        end
        ST_OS: begin
          os_ready    = 1'b1;
          sym_valid_d = 1'b1;
          cnt_inc     = 1'b1;
          if (os_valid_i) begin
            sym_data_d = os_data_i;
            if (os_last_i) state_d = ST_IDLE;
          end else begin
            sym_data_d = IDLE_CODE;
          end
        end
        ST_SKP: begin
          sym_data_d  = SKP_CODE;
          sym_valid_d = 1'b1;
          if (idx_q == SKP_LAST) begin
            skp_sent_d = 1'b1;
            idx_d      = '0;
            state_d    = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Saturating symbol counter; COM/SKP loads do not count, COM clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
    overrun_d = overrun_q | (cnt_d == CNT_MAX);
  end

  // State, output and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sym_data_q  <= '0;
      sym_valid_q <= 1'b0;
      skp_sent_q  <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      sym_data_q  <= sym_data_d;
      sym_valid_q <= sym_valid_d;
      skp_sent_q  <= skp_sent_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
    end
  end

  assign dat_ready_o   = dat_ready;
  assign os_ready_o    = os_ready;
  assign sym_data_o    = sym_data_q;
  assign sym_valid_o   = sym_valid_q;
  assign skp_sent_o    = skp_sent_q;
  assign skp_overrun_o = overrun_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler with SKP_INTERVAL=8, SKP_COUNT=3.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Ready outputs are checked after a further settle delay, before the next edge.
module tb_tx_symbol_scheduler;

  localparam logic [9:0] COM  = 10'h1BC;
  localparam logic [9:0] SKP  = 10'h11C;
  localparam logic [9:0] IDLE = 10'h000;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       dat_valid_i;
  logic       dat_ready_o;
  logic [9:0] dat_data_i;
  logic       dat_last_i;
  logic       os_valid_i;
  logic       os_ready_o;
  logic [9:0] os_data_i;
  logic       os_last_i;
  logic       out_ready_i;
  logic [9:0] sym_data_o;
  logic       sym_valid_o;
  logic       skp_sent_o;
  logic       skp_overrun_o;

  int errors = 0;
  int checks = 0;

  tx_symbol_scheduler #(
    .DATA_WIDTH  (10),
    .SKP_INTERVAL(8),
    .SKP_COUNT   (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .dat_valid_i  (dat_valid_i),
    .dat_ready_o  (dat_ready_o),
    .dat_data_i   (dat_data_i),
    .dat_last_i   (dat_last_i),
    .os_valid_i   (os_valid_i),
    .os_ready_o   (os_ready_o),
    .os_data_i    (os_data_i),
    .os_last_i    (os_last_i),
    .out_ready_i  (out_ready_i),
    .sym_data_o   (sym_data_o),
    .sym_valid_o  (sym_valid_o),
    .skp_sent_o   (skp_sent_o),
    .skp_overrun_o(skp_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Expect one loaded symbol with valid high and the given skp_sent level.
  task automatic expect_sym(input string tag, input logic [9:0] d, input logic sent);
    chk({tag, "_valid"}, 32'(sym_valid_o), 32'd1);
    chk({tag, "_data"}, 32'(sym_data_o), 32'(d));
    chk({tag, "_sent"}, 32'(skp_sent_o), 32'(sent));
  endtask

  // COM followed by three SKPs; dat_ready must stay low if a packet waits.
  task automatic expect_skp_set(input string tag, input logic dat_waiting);
    if (dat_waiting) begin
      #1 chk({tag, "_com_dat_ready"}, 32'(dat_ready_o), 32'd0);
    end
    step();
    expect_sym({tag, "_com"}, COM, 1'b0);
    for (int j = 0; j < 3; j++) begin
      if (dat_waiting) begin
        #1 chk({tag, "_skp_dat_ready"}, 32'(dat_ready_o), 32'd0);
      end
      step();
      expect_sym({tag, "_skp"}, SKP, (j == 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni      = 1'b1;
    en_i        = 1'b0;
    dat_valid_i = 1'b0;
    dat_data_i  = '0;
    dat_last_i  = 1'b0;
    os_valid_i  = 1'b0;
    os_data_i   = '0;
    os_last_i   = 1'b0;
    out_ready_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    // Reset state
    chk("rst_valid", 32'(sym_valid_o), 32'd0);
    chk("rst_data", 32'(sym_data_o), 32'd0);
    chk("rst_sent", 32'(skp_sent_o), 32'd0);
    chk("rst_overrun", 32'(skp_overrun_o), 32'd0);
    step();
    step();
    chk("rst_hold_valid", 32'(sym_valid_o), 32'd0);
    rst_ni = 1'b1;
    en_i   = 1'b1;

    // Idle link: 8 IDLE fills then COM + 3 SKP, twice.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) begin
        step();
        expect_sym("idle_fill", IDLE, 1'b0);
      end
      expect_skp_set("idle_skp", 1'b0);
    end

    // 6 IDLEs bring the counter to 6, then a 5-symbol packet; SKP follows ahead of a waiting packet.
    for (int i = 0; i < 6; i++) begin
      step();
      expect_sym("pre_pkt_idle", IDLE, 1'b0);
    end
    for (int i = 1; i <= 5; i++) begin
      dat_valid_i = 1'b1;
      dat_data_i  = 10'h0A0 + 10'(i);
      dat_last_i  = (i == 5);
      #1 chk("pkt5_ready", 32'(dat_ready_o), 32'd1);
      step();
      expect_sym("pkt5_sym", 10'h0A0 + 10'(i), 1'b0);
    end
    dat_data_i = 10'h0B0;
    dat_last_i = 1'b1;
    expect_skp_set("pkt5_skp", 1'b1);
    #1 chk("pkt_b0_ready", 32'(dat_ready_o), 32'd1);
    step();
    expect_sym("pkt_b0_sym", 10'h0B0, 1'b0);
    chk("pkt5_overrun", 32'(skp_overrun_o), 32'd0);
    dat_valid_i = 1'b0;

    // Backpressure mid-packet (counter 1 -> 5), stall must not count.
    for (int i = 1; i <= 2; i++) begin
      dat_valid_i = 1'b1;
      dat_data_i  = 10'h0C0 + 10'(i);
      dat_last_i  = 1'b0;
      step();
      expect_sym("bp_pre", 10'h0C0 + 10'(i), 1'b0);
    end
    dat_data_i  = 10'h0C3;
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_dat_ready", 32'(dat_ready_o), 32'd0);
      step();
      expect_sym("bp_hold", 10'h0C2, 1'b0);
    end
    out_ready_i = 1'b1;
    #1 chk("bp_resume_ready", 32'(dat_ready_o), 32'd1);
    step();
    expect_sym("bp_c3", 10'h0C3, 1'b0);
    dat_data_i = 10'h0C4;
    dat_last_i = 1'b1;
    step();
    expect_sym("bp_c4", 10'h0C4, 1'b0);
    dat_valid_i = 1'b0;
    dat_last_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_sym("bp_post_idle", IDLE, 1'b0);
    end

    // COM + 1 SKP, then asynchronous reset mid-set.
    step();
    expect_sym("rst_mid_com", COM, 1'b0);
    step();
    expect_sym("rst_mid_skp", SKP, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 32'(sym_valid_o), 32'd0);
    chk("async_rst_data", 32'(sym_data_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_sym("post_rst_idle", IDLE, 1'b0);
    end
    expect_skp_set("post_rst_skp", 1'b0);

    // TS1 and packet both requested: 16 OS symbols first, then SKP, then packet.
    os_valid_i  = 1'b1;
    dat_valid_i = 1'b1;
    dat_data_i  = 10'h0D1;
    dat_last_i  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      os_data_i = 10'h040 + 10'(i);
      os_last_i = (i == 15);
      #1;
      chk("ts1_os_ready", 32'(os_ready_o), 32'd1);
      chk("ts1_dat_ready", 32'(dat_ready_o), 32'd0);
      step();
      expect_sym("ts1_sym", 10'h040 + 10'(i), 1'b0);
      chk("ts1_overrun", 32'(skp_overrun_o), 32'(i == 15));
    end
    os_valid_i = 1'b0;
    os_last_i  = 1'b0;
    expect_skp_set("ts1_skp", 1'b1);
    #1 chk("ts1_pkt_ready", 32'(dat_ready_o), 32'd1);
    step();
    expect_sym("ts1_pkt_d1", 10'h0D1, 1'b0);
    dat_data_i = 10'h0D2;
    dat_last_i = 1'b1;
    step();
    expect_sym("ts1_pkt_d2", 10'h0D2, 1'b0);
    dat_valid_i = 1'b0;
    dat_last_i  = 1'b0;

    // Reset clears the sticky overrun flag.
    rst_ni = 1'b0;
    #1 chk("rst_overrun_clr", 32'(skp_overrun_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // 20-symbol packet from counter 0: overrun on symbol 16, SKP after symbol 20.
    for (int k = 1; k <= 20; k++) begin
      dat_valid_i = 1'b1;
      dat_data_i  = 10'h080 + 10'(k);
      dat_last_i  = (k == 20);
      step();
      expect_sym("long_sym", 10'h080 + 10'(k), 1'b0);
      chk("long_overrun", 32'(skp_overrun_o), 32'(k >= 16));
    end
    dat_valid_i = 1'b0;
    dat_last_i  = 1'b0;
    expect_skp_set("long_skp", 1'b0);

    // Underrun mid-packet fills IDLE and keeps DATA.
    dat_valid_i = 1'b1;
    dat_data_i  = 10'h0E1;
    step();
    expect_sym("under_e1", 10'h0E1, 1'b0);
    dat_valid_i = 1'b0;
    #1 chk("under_ready", 32'(dat_ready_o), 32'd1);
    step();
    expect_sym("under_fill", IDLE, 1'b0);
    dat_valid_i = 1'b1;
    dat_data_i  = 10'h0E2;
    dat_last_i  = 1'b1;
    step();
    expect_sym("under_e2", 10'h0E2, 1'b0);

    // Disabled lane in IDLE: nothing accepted, valid drops.
    en_i       = 1'b0;
    dat_data_i = 10'h0F0;
    #1 chk("dis_dat_ready", 32'(dat_ready_o), 32'd0);
    step();
    chk("dis_valid", 32'(sym_valid_o), 32'd0);
    chk("dis_overrun_sticky", 32'(skp_overrun_o), 32'd1);
    dat_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
